// File: rtl/sorter_pkg.sv
// Shared helpers for the bitonic sorter: network sizing and the static
// wiring/direction of every compare-exchange cell.
package sorter_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int stage_count(input int n);
      int l;
      l = clog2(n);
      return l * (l + 1) / 2;
   endfunction

   // Stage s belongs to merge phase p (block size 2^(p+1)); phases hold p+1 stages each.
   function automatic int stage_p(input int s);
      int r;
      int base;
      r    = 0;
      base = 0;
      for (int p = 0; p < 32; p++) begin
         if (s >= base + p + 1) begin
            base += p + 1;
            r     = p + 1;
         end
      end
      return r;
   endfunction

   // Compare distance exponent within the phase: p, p-1, ..., 0.
   function automatic int stage_q(input int s);
      int p;
      p = stage_p(s);
      return p - (s - p * (p + 1) / 2);
   endfunction

   function automatic int pair_partner(input int s, input int idx);
      return idx ^ (1 << stage_q(s));
   endfunction

   // Lower element index of cell c in stage s.
   function automatic int cell_lo(input int s, input int c);
      int q;
      q = stage_q(s);
      return ((c >> q) << (q + 1)) | (c & ((1 << q) - 1));
   endfunction

   // 0 = ascending block, 1 = descending block, chosen by the bit above the block size.
   function automatic logic cell_dir(input int s, input int idx);
      return ((idx >> (stage_p(s) + 1)) & 1) != 0;
   endfunction

endpackage

// File: rtl/pipelined_bitonic_sorter_cmp_exch.sv
// Combinational compare-exchange cell: dir=0 puts the minimum on lo, dir=1 the maximum.
// Equal inputs pass straight through.
module cmp_exch
   import sorter_pkg::*;
#(
   parameter int W      = 4,
   parameter int SIGNED = 0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         dir,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);

   logic a_gt_b;
   logic b_gt_a;
   logic swap;

   always_comb begin
      if (SIGNED != 0) begin
         a_gt_b = $signed(a) > $signed(b);
         b_gt_a = $signed(b) > $signed(a);
      end else begin
         a_gt_b = a > b;
         b_gt_a = b > a;
      end
      swap = dir ? b_gt_a : a_gt_b;
      lo   = swap ? b : a;
      hi   = swap ? a : b;
   end

endmodule

// File: rtl/pipelined_bitonic_sorter.sv
// Fully pipelined bitonic sorter: one registered compare-exchange stage per
// network column, valid/desc travel alongside, global stall on back-pressure.
module pipelined_bitonic_sorter
   import sorter_pkg::*;
#(
   parameter int N      = 8,
   parameter int W      = 4,
   parameter int SIGNED = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_desc,
   input  logic [N*W-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_desc,
   output logic [N*W-1:0] out_data
);

   localparam int S = stage_count(N);

   typedef logic [N-1:0][W-1:0] vec_t;

   vec_t         data_q [S];
   vec_t         data_d [S];
   vec_t         cx_out [S];
   vec_t         data_pipe [S+1];
   logic [S-1:0] vld_q, vld_d;
   logic [S-1:0] desc_q, desc_d;
   logic [S:0]   vld_pipe;
   logic [S:0]   desc_pipe;
   logic         stall;

   // Index s of each *_pipe is what feeds stage s; index S is the output.
   assign vld_pipe     = {vld_q, in_valid};
   assign desc_pipe    = {desc_q, in_desc};
   assign data_pipe[0] = in_data;

   assign stall     = vld_pipe[S] && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = vld_pipe[S];
   assign out_desc  = desc_pipe[S];
   assign out_data  = data_pipe[S];

   for (genvar s = 0; s < S; s++) begin : g_stage
      assign data_pipe[s+1] = data_q[s];
      for (genvar c = 0; c < N / 2; c++) begin : g_cell
         localparam int LO = cell_lo(s, c);
         localparam int HI = pair_partner(s, LO);
         cmp_exch #(.W(W), .SIGNED(SIGNED)) u_cx (
            .a   (data_pipe[s][LO]),
            .b   (data_pipe[s][HI]),
            .dir (cell_dir(s, LO) ^ desc_pipe[s]),
            .lo  (cx_out[s][LO]),
            .hi  (cx_out[s][HI])
         );
      end
   end

   always_comb begin
      vld_d  = vld_q;
      desc_d = desc_q;
      data_d = data_q;
      if (!stall) begin
         // in_ready is 1 whenever we get here, so in_valid alone marks acceptance.
         vld_d  = vld_pipe[S-1:0];
         desc_d = desc_pipe[S-1:0];
         data_d = cx_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         desc_q <= '0;
         for (int s = 0; s < S; s++) data_q[s] <= '0;
      end else begin
         vld_q  <= vld_d;
         desc_q <= desc_d;
         data_q <= data_d;
      end
   end

endmodule

// File: tb/tb_pipelined_bitonic_sorter.sv
// Scoreboard bench: drivers push expected sorted vectors, monitors pop and
// compare whenever an output handshake completes.
module tb_pipelined_bitonic_sorter;

   localparam int N = 8;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic           in_valid, in_ready, in_desc, out_valid, out_ready, out_desc;
   logic [N*W-1:0] in_data, out_data;

   logic        s_in_valid, s_in_ready, s_in_desc, s_out_valid, s_out_desc;
   logic [15:0] s_in_data, s_out_data;

   int checks = 0;
   int errors = 0;

   logic [N*W:0] exp_q[$];
   logic [16:0]  exps_q[$];

   pipelined_bitonic_sorter #(.N(N), .W(W), .SIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_desc(in_desc), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_desc(out_desc), .out_data(out_data)
   );

   pipelined_bitonic_sorter #(.N(4), .W(4), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_desc(s_in_desc), .in_data(s_in_data), .out_valid(s_out_valid),
      .out_ready(1'b1), .out_desc(s_out_desc), .out_data(s_out_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Independent reference: insertion sort of unsigned nibbles.
   function automatic logic [N*W-1:0] ref_sort(input logic [N*W-1:0] v, input logic desc);
      logic [W-1:0] e [N];
      logic [W-1:0] t;
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) e[i] = v[i*W +: W];
      for (int i = 1; i < N; i++) begin
         t = e[i];
         for (int j = i; j > 0; j--) begin
            if (desc ? (e[j-1] < t) : (e[j-1] > t)) begin
               e[j]   = e[j-1];
               e[j-1] = t;
            end
         end
      end
      for (int i = 0; i < N; i++) r[i*W +: W] = e[i];
      return r;
   endfunction

   task automatic send(input logic [N*W-1:0] d, input logic desc, input logic [N*W-1:0] exp_d);
      logic acc;
      int   guard;
      in_valid = 1'b1;
      in_data  = d;
      in_desc  = desc;
      guard    = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         guard++;
      end while (!acc && guard < 100);
      if (!acc) chk("accept_timeout", 0, 1);
      else exp_q.push_back({desc, exp_d});
      #1 in_valid = 1'b0;
   endtask

   task automatic send_s(input logic [15:0] d, input logic desc, input logic [15:0] exp_d);
      s_in_valid = 1'b1;
      s_in_data  = d;
      s_in_desc  = desc;
      @(posedge clk);
      exps_q.push_back({desc, exp_d});
      #1 s_in_valid = 1'b0;
   endtask

   task automatic latency_check(input string name);
      int cnt;
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         @(posedge clk);
         #1 cnt++;
      end
      chk(name, 64'(cnt), 64'd6);
   endtask

   // Main-instance monitor: handshakes and hold stability during stalls.
   initial begin
      logic         held_v;
      logic [N*W:0] held, e;
      held_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v = 1'b0;
         end else begin
            if (held_v) chk("stall_hold", 64'({out_desc, out_data}), 64'(held));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk("unexpected_out", 64'({out_desc, out_data}), 64'h1_0000_0000_dead);
               else begin
                  e = exp_q.pop_front();
                  chk("out_vec", 64'({out_desc, out_data}), 64'(e));
               end
            end
            held_v = out_valid && !out_ready;
            held   = {out_desc, out_data};
         end
      end
   end

   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && s_out_valid) begin
            if (exps_q.size() == 0) chk("unexpected_s_out", 64'({s_out_desc, s_out_data}), 64'h1dead);
            else begin
               e = exps_q.pop_front();
               chk("signed_vec", 64'({s_out_desc, s_out_data}), 64'(e));
            end
         end
      end
   end

   initial begin
      logic [N*W-1:0] v;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_desc    = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      s_in_valid = 1'b0;
      s_in_desc  = 1'b0;
      s_in_data  = '0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_data", 64'(out_data), 0);
      chk("rst_out_desc", 64'(out_desc), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(32'h45270173, 1'b0, 32'h77543210);
      latency_check("latency_asc");
      repeat (2) @(posedge clk);
      #1;
      send(32'h45270173, 1'b1, 32'h01234577);
      send(32'hF0F0F0F0, 1'b0, 32'hFFFF0000);
      send(32'h55555555, 1'b0, 32'h55555555);
      send(32'h55555555, 1'b1, 32'h55555555);

      send_s(16'h7F80, 1'b0, 16'h70F8);
      send_s(16'h7F80, 1'b1, 16'h8F07);
      repeat (10) @(posedge clk);
      #1;

      // Streaming with a 3-cycle consumer stall.
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               v = $urandom;
               send(v, 1'(i % 2), ref_sort(v, 1'(i % 2)));
            end
         end
         begin
            repeat (8) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", 64'(in_ready), 0);
               chk("stall_out_valid", 64'(out_valid), 1);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (12) @(posedge clk);
      #1;
      chk("stream_drained", 64'(exp_q.size()), 0);

      // Mid-stream asynchronous reset discards in-flight vectors.
      for (int i = 0; i < 3; i++) send(32'h12345678 + 32'(i), 1'b0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 0);
      chk("midrst_in_ready", 64'(in_ready), 1);
      chk("midrst_out_data", 64'(out_data), 0);
      exp_q.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h89ABCDEF, 1'b0, 32'hFEDCBA98);
      latency_check("latency_after_rst");

      for (int i = 0; i < 40 && (exp_q.size() != 0 || exps_q.size() != 0); i++) @(posedge clk);
      #1;
      chk("final_queue", 64'(exp_q.size()), 0);
      chk("final_queue_s", 64'(exps_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
